if_id_stage: RTL and testbench

IF_ID_STAGE -- requirements
Module: if_id_stage

---
 rtl/if_id_stage.sv | 119 +++++++++++
 tb/tb_if_id_stage.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/if_id_stage.sv
// if_id_stage: program counter plus IF/ID pipeline register with load-use hazard
// detection.
//
// Each rising edge does exactly one of three things, checked in this order:
//   flush   (PCSrc=1)        : redirect to branch_target and bubble IF/ID
//   stall   (hazard_stall=1) : hold the PC and IF/ID
//   advance (otherwise)      : capture inst_in at PC_Out, then PC_Out += 4
//
// Ports:
//   clk            in   rising-edge clock
//   reset          in   asynchronous active-low reset
//   inst_in        in   [31:0] instruction read from memory at PC_Out
//   PCSrc          in   taken-branch redirect from the branch unit
//   branch_target  in   [63:0] redirect address, taken as-is (may be unaligned)
//   idex_MemRead   in   MemRead of the instruction in ID/EX
//   idex_rd        in   [4:0] destination register of the instruction in ID/EX
//   PC_Out         out  [63:0] fetch address
//   PC_ifid        out  [63:0] PC of the instruction in IF/ID
//   inst_ifid      out  [31:0] instruction in IF/ID
//   valid_ifid     out  1 = IF/ID holds a real instruction
//   hazard_stall   out  combinational load-use stall
//   stall_count    out  [31:0] saturating count of stall edges
//                       (present only when STALL_COUNT_EN is defined)
//
// Build option: define STALL_COUNT_EN to add the stall_count output.
module if_id_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] inst_in,
  input  logic        PCSrc,
  input  logic [63:0] branch_target,
  input  logic        idex_MemRead,
  input  logic [4:0]  idex_rd,
  output logic [63:0] PC_Out,
  output logic [63:0] PC_ifid,
  output logic [31:0] inst_ifid,
  output logic        valid_ifid,
`ifdef STALL_COUNT_EN
  output logic [31:0] stall_count,
`endif
  output logic        hazard_stall
);

  logic [63:0] pc_q, pc_d;
  logic [63:0] pc_ifid_q, pc_ifid_d;
  logic [31:0] inst_ifid_q, inst_ifid_d;
  logic        valid_q, valid_d;

  logic [4:0]  rs1, rs2;
  logic        hazard;

  assign rs1 = inst_ifid_q[19:15];
  assign rs2 = inst_ifid_q[24:20];

  // x0 is never a real dependency, and a bubble's stale fields must not stall.
  assign hazard = idex_MemRead && (idex_rd != 5'd0) && valid_q &&
                  ((idex_rd == rs1) || (idex_rd == rs2));

  always_comb begin
    pc_d        = pc_q;
    pc_ifid_d   = pc_ifid_q;
    inst_ifid_d = inst_ifid_q;
    valid_d     = valid_q;
    if (PCSrc) begin
      pc_d        = branch_target;
      pc_ifid_d   = 64'd0;
      inst_ifid_d = 32'd0;
      valid_d     = 1'b0;
    end else if (!hazard) begin
      pc_d        = pc_q + 64'd4;  // wraps modulo 2^64
      pc_ifid_d   = pc_q;
      inst_ifid_d = inst_in;
      valid_d     = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q        <= 64'd0;
      pc_ifid_q   <= 64'd0;
      inst_ifid_q <= 32'd0;
      valid_q     <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      pc_ifid_q   <= pc_ifid_d;
      inst_ifid_q <= inst_ifid_d;
      valid_q     <= valid_d;
    end
  end

`ifdef STALL_COUNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Counts only true stall edges; a flush edge wins even if hazard is high.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!PCSrc && hazard && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;
`endif

  assign PC_Out       = pc_q;
  assign PC_ifid      = pc_ifid_q;
  assign inst_ifid    = inst_ifid_q;
  assign valid_ifid   = valid_q;
  assign hazard_stall = hazard;

endmodule

// File: tb/tb_if_id_stage.sv
// Directed self-checking bench for if_id_stage.
module tb_if_id_stage;

  logic        clk;
  logic        reset;
  logic [31:0] inst_in;
  logic        PCSrc;
  logic [63:0] branch_target;
  logic        idex_MemRead;
  logic [4:0]  idex_rd;
  logic [63:0] PC_Out;
  logic [63:0] PC_ifid;
  logic [31:0] inst_ifid;
  logic        valid_ifid;
  logic        hazard_stall;
`ifdef STALL_COUNT_EN
  logic [31:0] stall_count;
`endif

  int n_checks;
  int n_fail;

  if_id_stage u_dut (
    .clk           (clk),
    .reset         (reset),
    .inst_in       (inst_in),
    .PCSrc         (PCSrc),
    .branch_target (branch_target),
    .idex_MemRead  (idex_MemRead),
    .idex_rd       (idex_rd),
    .PC_Out        (PC_Out),
    .PC_ifid       (PC_ifid),
    .inst_ifid     (inst_ifid),
    .valid_ifid    (valid_ifid),
`ifdef STALL_COUNT_EN
    .stall_count   (stall_count),
`endif
    .hazard_stall  (hazard_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge, then sample away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero_state(input string tag);
    check_eq({tag, ".pc_out"},  PC_Out,       64'd0);
    check_eq({tag, ".pc_ifid"}, PC_ifid,      64'd0);
    check_eq({tag, ".inst"},    inst_ifid,    64'd0);
    check_eq({tag, ".valid"},   valid_ifid,   64'd0);
    check_eq({tag, ".hazard"},  hazard_stall, 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    reset         = 1'b0;
    inst_in       = 32'h0000_0013;
    PCSrc         = 1'b0;
    branch_target = 64'd0;
    idex_MemRead  = 1'b0;
    idex_rd       = 5'd0;

    // Reset held across edges
    step();
    step();
    check_zero_state("rst");
`ifdef STALL_COUNT_EN
    check_eq("rst.cnt", stall_count, 64'd0);
`endif

    // Release reset; first edge fetches from address 0
    reset = 1'b1;
    step();
    check_eq("e1.pc_ifid", PC_ifid,    64'd0);
    check_eq("e1.inst",    inst_ifid,  64'h13);
    check_eq("e1.valid",   valid_ifid, 64'd1);
    check_eq("e1.pc_out",  PC_Out,     64'd4);
    inst_in = 32'h0020_81B3;  // add x3,x1,x2
    step();
    check_eq("e2.pc_out",  PC_Out,    64'd8);
    check_eq("e2.pc_ifid", PC_ifid,   64'd4);
    check_eq("e2.inst",    inst_ifid, 64'h0020_81B3);

    // Load-use on rs2
    idex_MemRead = 1'b1;
    idex_rd      = 5'd2;
    inst_in      = 32'hDEAD_BEEF;
    #1;
    check_eq("lu.hazard", hazard_stall, 64'd1);
    step();
    check_eq("lu.pc_out",  PC_Out,     64'd8);
    check_eq("lu.pc_ifid", PC_ifid,    64'd4);
    check_eq("lu.inst",    inst_ifid,  64'h0020_81B3);
    check_eq("lu.valid",   valid_ifid, 64'd1);
`ifdef STALL_COUNT_EN
    check_eq("lu.cnt", stall_count, 64'd1);
`endif
    idex_MemRead = 1'b0;
    inst_in      = 32'h0010_0093;  // addi x1,x0,1
    #1;
    check_eq("lu2.hazard", hazard_stall, 64'd0);
    step();
    check_eq("lu2.pc_ifid", PC_ifid,   64'd8);
    check_eq("lu2.inst",    inst_ifid, 64'h0010_0093);
    check_eq("lu2.pc_out",  PC_Out,    64'hC);

    // idex_rd = x0 matches rs1=0 but never stalls
    idex_MemRead = 1'b1;
    idex_rd      = 5'd0;
    inst_in      = 32'h0020_81B3;
    #1;
    check_eq("x0.hazard", hazard_stall, 64'd0);
    step();
    check_eq("x0.pc_ifid", PC_ifid, 64'hC);
    check_eq("x0.pc_out",  PC_Out,  64'h10);

    // Load-use on rs1, with a simultaneous flush that must win
    idex_rd = 5'd1;
    #1;
    check_eq("fl.hazard_pre", hazard_stall, 64'd1);
    PCSrc         = 1'b1;
    branch_target = 64'h100;
    step();
    check_eq("fl.pc_out",  PC_Out,       64'h100);
    check_eq("fl.pc_ifid", PC_ifid,      64'd0);
    check_eq("fl.inst",    inst_ifid,    64'd0);
    check_eq("fl.valid",   valid_ifid,   64'd0);
    check_eq("fl.hazard",  hazard_stall, 64'd0);
`ifdef STALL_COUNT_EN
    check_eq("fl.cnt", stall_count, 64'd1);
`endif
    PCSrc        = 1'b0;
    idex_MemRead = 1'b0;
    inst_in      = 32'h0000_0013;
    step();
    check_eq("bt.pc_ifid", PC_ifid,    64'h100);
    check_eq("bt.pc_out",  PC_Out,     64'h104);
    check_eq("bt.valid",   valid_ifid, 64'd1);

    // Unaligned redirect keeps the +4 stride from the odd address
    PCSrc         = 1'b1;
    branch_target = 64'h103;
    step();
    check_eq("ua.pc_out", PC_Out, 64'h103);
    PCSrc = 1'b0;
    step();
    check_eq("ua.pc_out2", PC_Out,  64'h107);
    check_eq("ua.pc_ifid", PC_ifid, 64'h103);

    // 64-bit wrap
    PCSrc         = 1'b1;
    branch_target = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    PCSrc   = 1'b0;
    inst_in = 32'h0020_81B3;
    step();
    check_eq("wr.pc_out",  PC_Out,  64'd0);
    check_eq("wr.pc_ifid", PC_ifid, 64'hFFFF_FFFF_FFFF_FFFC);

    // Stall, then an asynchronous reset pulse between edges
    idex_MemRead = 1'b1;
    idex_rd      = 5'd2;
    step();
    check_eq("st.pc_out", PC_Out, 64'd0);
    check_eq("st.valid",  valid_ifid, 64'd1);
`ifdef STALL_COUNT_EN
    check_eq("st.cnt", stall_count, 64'd2);
`endif
    check_eq("st.hazard", hazard_stall, 64'd1);
    #1;
    reset = 1'b0;
    #1;
    check_zero_state("ar");
`ifdef STALL_COUNT_EN
    check_eq("ar.cnt", stall_count, 64'd0);
`endif
    idex_MemRead = 1'b0;
    inst_in      = 32'h0000_0013;
    #1;
    reset = 1'b1;
    step();
    check_eq("rs.pc_ifid", PC_ifid,    64'd0);
    check_eq("rs.inst",    inst_ifid,  64'h13);
    check_eq("rs.valid",   valid_ifid, 64'd1);
    check_eq("rs.pc_out",  PC_Out,     64'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
